// File: rtl/nios2_cpu_debug_ocimem_exec_if.sv
// Debug-memory executor bus bundle: JTAG-side command inputs, Avalon-MM
// master port and the monitor status returned to the debug slave.
interface nios2_cpu_debug_ocimem_exec_if #(
  parameter int unsigned ADDR_W = 16
);
  // Command side, from the debug slave sysclk stage
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;

  // Avalon-MM master port
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  // Monitor status back to the debug slave
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              monitor_ready;
  logic              monitor_error;

  // Executor side: consumes commands, masters the Avalon bus
  modport master (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b,
           take_no_action_ocimem_a, avm_readdata, avm_waitrequest,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           MonDReg, MonAReg, monitor_ready, monitor_error
  );

  // Environment side: debug slave plus Avalon slave
  modport slave (
    output jdo, take_action_ocimem_a, take_action_ocimem_b,
           take_no_action_ocimem_a, avm_readdata, avm_waitrequest,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           MonDReg, MonAReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/nios2_cpu_debug_ocimem_exec.sv
// Executes debug memory reads/writes requested over the JTAG debug slave on
// an Avalon-MM master port, with stall timeout and sticky error reporting.
module nios2_cpu_debug_ocimem_exec #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  nios2_cpu_debug_ocimem_exec_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [15:0]       TMO_LIMIT = 16'(TIMEOUT);
  localparam logic [31:0]       RD_ABORT  = 32'hDEADBEEF;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              err_set, err_clr;
  logic              any_strobe;

  // jdo bits never consumed by any command
  logic unused_jdo;
  assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[1:0]};

  assign any_strobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                      bus.take_no_action_ocimem_a;

  // State, address/data registers, stall counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Command decode, transfer handshake and timeout next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    err_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.take_action_ocimem_b) begin
          data_d  = bus.jdo[34:3];
          tmo_d   = '0;
          state_d = WR;
        end else if (bus.take_action_ocimem_a) begin
          if (bus.jdo[35]) begin
            addr_d = bus.jdo[ADDR_W+1:2];
            if (bus.jdo[34]) begin
              tmo_d   = '0;
              state_d = RD;
            end
          end else begin
            err_clr = 1'b1;
          end
        end else if (bus.take_no_action_ocimem_a) begin
          tmo_d   = '0;
          state_d = RD;
        end
      end

      RD, WR: begin
        // Commands arriving mid-transfer are dropped and flagged
        if (any_strobe) begin
          err_set = 1'b1;
        end
        if (!bus.avm_waitrequest) begin
          if (state_q == RD) begin
            data_d = bus.avm_readdata;
          end
          addr_d  = addr_q + ADDR_ONE;
          state_d = IDLE;
        end else if (tmo_q == TMO_LIMIT) begin
          err_set = 1'b1;
          if (state_q == RD) begin
            data_d = RD_ABORT;
          end
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Error set wins over a same-cycle clear
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Requests and status decode straight from registered state, so the
  // address and write data hold steady for the whole stalled request
  always_comb begin
    bus.avm_read       = (state_q == RD);
    bus.avm_write      = (state_q == WR);
    bus.avm_address    = addr_q;
    bus.avm_writedata  = data_q;
    bus.avm_byteenable = '1;
    bus.MonDReg        = data_q;
    bus.MonAReg        = addr_q;
    bus.monitor_ready  = (state_q == IDLE);
    bus.monitor_error  = err_q;
  end

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem_exec.sv
// Self-checking bench for the debug memory executor: directed scenarios
// followed by randomized commands checked against a transaction-level model.
module tb_nios2_cpu_debug_ocimem_exec;

  localparam int unsigned AW  = 16;
  localparam int unsigned TMO = 255;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic          m_err;

  nios2_cpu_debug_ocimem_exec_if #(.ADDR_W(AW)) bus ();

  nios2_cpu_debug_ocimem_exec #(
    .ADDR_W (AW),
    .TIMEOUT(TMO)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input bit load, input bit rd, input logic [AW-1:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = load;
    j[34] = rd;
    j[AW+1:2] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, ".addr"},  32'(bus.MonAReg), 32'(m_addr));
    chk({tag, ".data"},  bus.MonDReg, m_data);
    chk({tag, ".ready"}, 32'(bus.monitor_ready), 32'd1);
    chk({tag, ".err"},   32'(bus.monitor_error), 32'(m_err));
  endtask

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a.
  // stalls: waitrequest cycles before completion; beyond TMO means abort.
  task automatic xfer(input string tag, input int kind, input logic [37:0] j,
                      input int stalls, input logic [31:0] rd, input bit inject);
    bit            starts, is_wr, aborted, done;
    int            cyc, left, exp_cyc;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wd;

    starts = (kind == 1) || (kind == 2) || (kind == 0 && j[35] && j[34]);
    is_wr  = (kind == 1);
    if (kind == 1) m_data = j[34:3];
    if (kind == 0) begin
      if (j[35]) m_addr = j[AW+1:2];
      else       m_err  = 1'b0;
    end
    exp_addr = m_addr;
    exp_wd   = m_data;

    @(negedge clk);
    bus.take_action_ocimem_a    = (kind == 0);
    bus.take_action_ocimem_b    = (kind == 1);
    bus.take_no_action_ocimem_a = (kind == 2);
    bus.jdo                     = j;
    bus.avm_readdata            = rd;
    bus.avm_waitrequest         = 1'b0;
    @(negedge clk);
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;

    cyc  = 0;
    left = stalls;
    done = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (!(bus.avm_read || bus.avm_write)) begin
        done = 1'b1;
        break;
      end
      cyc++;
      chk({tag, ".is_write"}, 32'(bus.avm_write), 32'(is_wr));
      chk({tag, ".avm_addr"}, 32'(bus.avm_address), 32'(exp_addr));
      chk({tag, ".ready_busy"}, 32'(bus.monitor_ready), 32'd0);
      if (is_wr) chk({tag, ".wdata"}, bus.avm_writedata, exp_wd);
      bus.take_no_action_ocimem_a = inject && (cyc == 1);
      bus.avm_waitrequest         = (left > 0);
      if (left > 0) left--;
      @(negedge clk);
    end
    bus.take_no_action_ocimem_a = 1'b0;
    bus.avm_waitrequest         = 1'b0;
    if (!done) chk({tag, ".bounded_wait"}, 32'd1, 32'd0);

    aborted = starts && (stalls > int'(TMO));
    exp_cyc = !starts ? 0 : (aborted ? int'(TMO) + 1 : stalls + 1);
    if (starts) begin
      if (aborted) begin
        m_err = 1'b1;
        if (!is_wr) m_data = 32'hDEADBEEF;
      end else begin
        if (!is_wr) m_data = rd;
        m_addr = m_addr + 1'b1;
      end
      if (inject && stalls >= 1) m_err = 1'b1;
    end
    chk({tag, ".req_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk_status(tag);
  endtask

  initial begin
    bus.jdo                     = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.avm_readdata            = '0;
    bus.avm_waitrequest         = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 1'b0;

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.read",  32'(bus.avm_read),  32'd0);
    chk("rst.write", 32'(bus.avm_write), 32'd0);
    chk("rst.be",    32'(bus.avm_byteenable), 32'hF);
    chk_status("rst");

    // Address load without read: no bus activity
    xfer("aload", 0, mk_a(1'b1, 1'b0, 16'h0040), 0, 32'h0, 1'b0);
    // Zero-wait write
    xfer("wr0", 1, mk_b(32'hCAFE0001), 0, 32'h0, 1'b0);
    chk("wr0.addr_const", 32'(bus.MonAReg), 32'h0041);
    // Read with three stall cycles
    xfer("rd3", 2, '0, 3, 32'h12345678, 1'b0);
    chk("rd3.data_const", bus.MonDReg, 32'h12345678);
    // Read completing on the last stall cycle before abort
    xfer("rd_edge", 2, '0, int'(TMO), 32'hA5A5F00D, 1'b0);
    // Read stuck until timeout
    xfer("rd_tmo", 2, '0, 5000, 32'h11111111, 1'b0);
    chk("rd_tmo.dead", bus.MonDReg, 32'hDEADBEEF);
    // Clear sticky error
    xfer("clr", 0, mk_a(1'b0, 1'b0, 16'h0000), 0, 32'h0, 1'b0);
    // Strobe during stalled read: dropped, error set, read still completes
    xfer("busy", 2, '0, 5, 32'h0BADC0DE, 1'b1);
    xfer("clr2", 0, mk_a(1'b0, 1'b0, 16'h0000), 0, 32'h0, 1'b0);
    // Load-and-read via ocimem_a
    xfer("aload_rd", 0, mk_a(1'b1, 1'b1, 16'h1234), 2, 32'h76543210, 1'b0);
    // Write timeout keeps MonDReg
    xfer("wr_tmo", 1, mk_b(32'h5555AAAA), 400, 32'h0, 1'b0);
    xfer("clr3", 0, mk_a(1'b0, 1'b0, 16'h0000), 0, 32'h0, 1'b0);
    // Address wrap
    xfer("wrap_ld", 0, mk_a(1'b1, 1'b0, 16'hFFFF), 0, 32'h0, 1'b0);
    xfer("wrap_wr", 1, mk_b(32'h01020304), 0, 32'h0, 1'b0);
    chk("wrap.addr_const", 32'(bus.MonAReg), 32'h0000);

    // Randomized command mix
    for (int n = 0; n < 40; n++) begin
      int          kind, stalls;
      logic [37:0] j;
      bit          inj;
      kind   = int'($urandom_range(0, 2));
      j      = {6'($urandom), 32'($urandom)};
      stalls = ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(0, 4));
      inj    = (stalls >= 1) && ($urandom_range(0, 3) == 0);
      xfer($sformatf("rnd%0d", n), kind, j, stalls, 32'($urandom), inj);
    end

    // Reset during a stalled write
    @(negedge clk);
    bus.take_action_ocimem_b = 1'b1;
    bus.jdo                  = mk_b(32'h77778888);
    bus.avm_waitrequest      = 1'b1;
    @(negedge clk);
    bus.take_action_ocimem_b = 1'b0;
    chk("rstw.write_on", 32'(bus.avm_write), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 1'b0;
    chk("rstw.write_off", 32'(bus.avm_write), 32'd0);
    chk("rstw.read_off",  32'(bus.avm_read),  32'd0);
    chk_status("rstw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_cpu_debug_ocimem_exec.md
Name: nios2_cpu_debug_ocimem_exec

Overview:
- Sysclk-domain executor directly downstream of the debug slave wrapper. Consumes its jdo bus and ocimem action strobes.
- Performs the requested debug memory reads/writes on an Avalon-MM master port.
- Returns read data and status to the debug slave inputs MonDReg, monitor_ready and monitor_error, so the JTAG host can read back results.

Parameters:
ADDR_W, 16, word-address width of avm_address (1..32)
TIMEOUT, 255, max cycles avm_waitrequest may stall one transfer before abort (1..65535)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
jdo  in  38  captured JTAG data from debug slave sysclk stage
take_action_ocimem_a  in  1  one-cycle strobe: address load / optional read
take_action_ocimem_b  in  1  one-cycle strobe: write data and start write
take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address
avm_address  out  ADDR_W  word address (= MonAReg while transfer active)
avm_read  out  1  Avalon read request
avm_write  out  1  Avalon write request
avm_writedata  out  32  write data (= MonDReg)
avm_byteenable  out  4  constant 4'hF
avm_readdata  in  32  read data, valid when avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
MonDReg  out  32  data register, returned to debug slave
MonAReg  out  ADDR_W  current word address
monitor_ready  out  1  1 = idle, result valid
monitor_error  out  1  sticky error flag

Behaviour:
- Reset values (on clk edge with reset=1): state IDLE, MonAReg=0, MonDReg=0, avm_read=0, avm_write=0, monitor_ready=1, monitor_error=0, timeout counter=0.
- Reset mid-transfer: aborts immediately; no increment; outputs take the reset values above.
- FSM states: IDLE, RD, WR.
- Command decode in IDLE. Strobes are normally exclusive; if several are high, priority is ocimem_b > ocimem_a > no_action_ocimem_a.
  - ocimem_a, jdo[35]=1: MonAReg <= jdo[ADDR_W+1:2]. If jdo[34]=1, also go to RD next cycle.
  - ocimem_a, jdo[35]=0: clear monitor_error only.
  - ocimem_b: MonDReg <= jdo[34:3]; go to WR.
  - no_action_ocimem_a: go to RD at current MonAReg.
- Accepting a command that starts a transfer: avm_read or avm_write rises and monitor_ready falls on the next edge (1-cycle latency).
- RD:
  - avm_read=1 held until avm_waitrequest=0.
  - In that cycle: MonDReg <= avm_readdata, MonAReg <= MonAReg+1 (mod 2^ADDR_W).
  - Next edge: avm_read=0, monitor_ready=1, state IDLE.
  - Zero-wait read: avm_read high for exactly 1 cycle.
- WR: same handshake with avm_write; MonDReg unchanged; MonAReg increments on completion.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle with waitrequest=1.
  - When it reaches TIMEOUT with waitrequest still 1: drop request, monitor_error=1, MonAReg not incremented, return to IDLE with monitor_ready=1.
  - A read timeout also sets MonDReg=32'hDEADBEEF.
- Busy drop: any strobe while state != IDLE is ignored entirely (no register load) and sets monitor_error=1.
- monitor_error clears only via reset or ocimem_a with jdo[35]=0. Setting takes precedence if set and clear fall in the same cycle.
- Address wrap: MonAReg = 2^ADDR_W-1 increments to 0 with no error.
- avm_address/avm_writedata are stable for the whole request while waitrequest=1.

Test Plan:
- Reset, then ocimem_a with jdo[35]=1, jdo[34]=0, jdo[17:2]=16'h0040 -> MonAReg=16'h0040; no Avalon activity; monitor_ready stays 1.
- ocimem_b with jdo[34:3]=32'hCAFE0001, waitrequest=0 -> 1-cycle avm_write at address 16'h0040 with writedata 32'hCAFE0001; then MonAReg=16'h0041, monitor_ready=1.
- no_action_ocimem_a, waitrequest=1 for 3 cycles, readdata=32'h12345678 -> avm_read high 4 cycles; MonDReg=32'h12345678; MonAReg +1; monitor_error=0.
- Read with waitrequest stuck at 1, TIMEOUT=255 -> request dropped after 255 stall cycles; monitor_error=1; MonDReg=32'hDEADBEEF; MonAReg unchanged. Then ocimem_a with jdo[35]=0 -> monitor_error=0.
- Second no_action strobe during a stalled read -> ignored; monitor_error=1; the original read completes normally.
- MonAReg=16'hFFFF, zero-wait write -> MonAReg=16'h0000. Assert reset during a stalled write -> avm_write=0 and MonAReg=0 on the next edge.
